// File: rtl/ysyx_23060061_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite-style arbiter.
// Round-robin grant; one complete transaction per grant, channels routed combinationally.
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read port
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    // LSU read/write port
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic                lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // memory slave port
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic                mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

    state_t state_reg, state_next;
    logic   last_grant_reg, last_grant_next;   // 1 = LSU was granted last
    logic   aw_done_reg, aw_done_next;
    logic   w_done_reg, w_done_next;

    logic ifu_req, lsu_req, grant_lsu;
    logic aw_hs, w_hs;

    assign ifu_req   = ifu_arvalid;
    assign lsu_req   = lsu_arvalid | lsu_awvalid;
    // LSU wins when it is alone, or on a tie when the IFU had the last grant
    assign grant_lsu = lsu_req & (~ifu_req | ~last_grant_reg);
    assign aw_hs     = lsu_awvalid & ~aw_done_reg & mem_awready;
    assign w_hs      = lsu_wvalid & ~w_done_reg & mem_wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        aw_done_next    = aw_done_reg;
        w_done_next     = w_done_reg;
        case (state_reg)
            IDLE: begin
                if (grant_lsu) begin
                    last_grant_next = 1'b1;
                    state_next      = lsu_arvalid ? LSU_RD : LSU_WR;
                end else if (ifu_req) begin
                    last_grant_next = 1'b0;
                    state_next      = IFU_RD;
                end
            end
            IFU_RD: if (mem_rvalid && ifu_rready) state_next = IDLE;
            LSU_RD: if (mem_rvalid && lsu_rready) state_next = IDLE;
            LSU_WR: begin
                if (aw_hs) aw_done_next = 1'b1;
                if (w_hs)  w_done_next  = 1'b1;
                if (mem_bvalid && lsu_bready) begin
                    state_next   = IDLE;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 1'b0;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;
        case (state_reg)
            IFU_RD: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid;
                ifu_arready = mem_arready;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
            end
            LSU_RD: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid;
                lsu_arready = mem_arready;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
            end
            LSU_WR: begin
                // AW and W each handshake once; the done flags hide a still-held valid
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid & ~aw_done_reg;
                lsu_awready = mem_awready & ~aw_done_reg;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid & ~w_done_reg;
                lsu_wready  = mem_wready & ~w_done_reg;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule
